fan_level_ctrl: RTL and testbench

FAN_LEVEL_CTRL -- requirements
Module: fan_level_ctrl

---
 rtl/fan_pkg.sv | 15 +
 rtl/fan_level_ctrl_btn_repeat.sv | 63 ++++++
 rtl/fan_level_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fan_level_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared types for the fan speed controller: operating states and the
// width helper used to size the level bus.
package fan_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } fan_state_e;

  function automatic int level_width(input int levels);
    return $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/fan_level_ctrl_btn_repeat.sv
// Edge detection plus hold-to-repeat for one speed button.
// Emits a one-cycle step on the press edge and on each repeat tick.
module btn_repeat #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic other_btn,
  input  logic enable,
  output logic step
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  logic          btn_q, btn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dly_q, dly_d;
  logic          press;
  logic          solo;

  assign press = btn && !btn_q;
  assign solo  = btn && !other_btn && enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      dly_q <= 1'b1;
    end else begin
      btn_q <= btn_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
    end
  end

  // cnt_q holds edges elapsed since the last step; dly_q marks the long first gap
  always_comb begin
    btn_d = btn;
    cnt_d = cnt_q;
    dly_d = dly_q;
    step  = 1'b0;
    if (!solo) begin
      cnt_d = '0;
      dly_d = 1'b1;
    end else if (press) begin
      step  = 1'b1;
      cnt_d = '0;
      dly_d = 1'b1;
    end else if (dly_q ? (cnt_q == DLY_LAST) : (cnt_q == PER_LAST)) begin
      step  = 1'b1;
      cnt_d = '0;
      dly_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fan_level_ctrl.sv
// Fan speed controller: power/up/down/sleep buttons drive OFF/RUN/SLEEP and a level bar.
// Sleep timer is built only when FAN_LEVEL_CTRL_SLEEP_EN is defined.
module fan_level_ctrl
  import fan_pkg::*;
#(
  parameter int          LEVELS       = 7,
  parameter int          INIT_LEVEL   = 1,
  parameter int          REPEAT_DLY   = 50_000_000,
  parameter int          REPEAT_PER   = 12_500_000,
  parameter logic [31:0] SLEEP_CYCLES = 32'd3_000_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             power_btn,
  input  logic                             up_btn,
  input  logic                             down_btn,
  input  logic                             sleep_btn,
  output logic [level_width(LEVELS)-1:0]   level,
  output logic [LEVELS-1:0]                bar,
  output logic                             fan_on,
  output logic                             sleep_active
);

  localparam int LW = level_width(LEVELS);
  localparam logic [LW-1:0] MAX_LVL  = LW'(LEVELS);
  localparam logic [LW-1:0] MIN_LVL  = LW'(1);
  localparam logic [LW-1:0] INIT_LVL = LW'(INIT_LEVEL);

  fan_state_e        state_q, state_d;
  logic [LW-1:0]     mem_q, mem_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LEVELS-1:0] bar_q, bar_d;
  logic              fan_on_q, fan_on_d;
  logic              sleep_active_q, sleep_active_d;
  logic              power_prev_q, power_prev_d;
  logic              power_press;
  logic              running;
  logic              step_ok;
  logic              up_step, down_step;

  assign power_press = power_btn && !power_prev_q;
  assign running     = (state_q != OFF);

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_up_repeat (
    .clk       (clk),
    .rst       (rst),
    .btn       (up_btn),
    .other_btn (down_btn),
    .enable    (running),
    .step      (up_step)
  );

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_down_repeat (
    .clk       (clk),
    .rst       (rst),
    .btn       (down_btn),
    .other_btn (up_btn),
    .enable    (running),
    .step      (down_step)
  );

`ifdef FAN_LEVEL_CTRL_SLEEP_EN
  logic        sleep_prev_q, sleep_prev_d;
  logic        sleep_press;
  logic [31:0] sleep_cnt_q, sleep_cnt_d;

  assign sleep_press = sleep_btn && !sleep_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sleep_prev_q <= 1'b0;
      sleep_cnt_q  <= '0;
    end else begin
      sleep_prev_q <= sleep_prev_d;
      sleep_cnt_q  <= sleep_cnt_d;
    end
  end
`else
  logic unused_sleep_btn;
  assign unused_sleep_btn = sleep_btn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= OFF;
      mem_q          <= INIT_LVL;
      level_q        <= '0;
      bar_q          <= '0;
      fan_on_q       <= 1'b0;
      sleep_active_q <= 1'b0;
      power_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      level_q        <= level_d;
      bar_q          <= bar_d;
      fan_on_q       <= fan_on_d;
      sleep_active_q <= sleep_active_d;
      power_prev_q   <= power_prev_d;
    end
  end

  // Outputs are derived from the next state so a press shows up right after its edge
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    power_prev_d = power_btn;
    step_ok      = running && !power_press;
`ifdef FAN_LEVEL_CTRL_SLEEP_EN
    sleep_prev_d = sleep_btn;
    sleep_cnt_d  = sleep_cnt_q;
`endif

    if (step_ok && up_step && (mem_q < MAX_LVL)) begin
      mem_d = mem_q + LW'(1);
    end else if (step_ok && down_step && (mem_q > MIN_LVL)) begin
      mem_d = mem_q - LW'(1);
    end

    case (state_q)
      OFF: begin
        if (power_press) state_d = RUN;
      end
      RUN: begin
        if (power_press) begin
          state_d = OFF;
`ifdef FAN_LEVEL_CTRL_SLEEP_EN
        end else if (sleep_press) begin
          state_d     = SLEEP;
          sleep_cnt_d = SLEEP_CYCLES - 32'd1;
`endif
        end
      end
      SLEEP: begin
`ifdef FAN_LEVEL_CTRL_SLEEP_EN
        if (power_press) begin
          state_d     = OFF;
          sleep_cnt_d = '0;
        end else if (sleep_press) begin
          state_d     = RUN;
          sleep_cnt_d = '0;
        end else if (sleep_cnt_q == 32'd0) begin
          state_d = OFF;
        end else begin
          sleep_cnt_d = sleep_cnt_q - 32'd1;
        end
`else
        state_d = OFF;
`endif
      end
      default: state_d = OFF;
    endcase

    level_d        = (state_d == OFF) ? '0 : mem_d;
    fan_on_d       = (state_d != OFF);
    sleep_active_d = (state_d == SLEEP);
    bar_d          = '0;
    for (int i = 0; i < LEVELS; i++) begin
      bar_d[i] = fan_on_d && (int'(level_d) > i);
    end
  end

  assign level        = level_q;
  assign bar          = bar_q;
  assign fan_on       = fan_on_q;
  assign sleep_active = sleep_active_q;

endmodule

// File: tb/tb_fan_level_ctrl.sv
// Directed self-checking bench for fan_level_ctrl (LEVELS=7, short repeat/sleep timings).
// Sleep scenarios are exercised when FAN_LEVEL_CTRL_SLEEP_EN is defined.
module tb_fan_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_btn, up_btn, down_btn, sleep_btn;
  logic [2:0] level;
  logic [6:0] bar;
  logic       fan_on, sleep_active;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fan_level_ctrl #(
    .LEVELS       (7),
    .INIT_LEVEL   (1),
    .REPEAT_DLY   (10),
    .REPEAT_PER   (4),
    .SLEEP_CYCLES (32'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .power_btn    (power_btn),
    .up_btn       (up_btn),
    .down_btn     (down_btn),
    .sleep_btn    (sleep_btn),
    .level        (level),
    .bar          (bar),
    .fan_on       (fan_on),
    .sleep_active (sleep_active)
  );

  // Drive the buttons, then let the given number of clock edges pass
  task automatic applyStimulus(input logic p, input logic u, input logic d,
                               input logic s, input int cycles);
    power_btn = p;
    up_btn    = u;
    down_btn  = d;
    sleep_btn = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pressBtn(input logic p, input logic u, input logic d, input logic s);
    applyStimulus(p, u, d, s, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_level,
                             input logic [6:0] exp_bar, input logic exp_fan,
                             input logic exp_sleep);
    checks++;
    assert (level === exp_level) else begin
      fails++;
      $error("[TB] FAIL %s level: got %0d expected %0d", tag, level, exp_level);
    end
    checks++;
    assert (bar === exp_bar) else begin
      fails++;
      $error("[TB] FAIL %s bar: got %b expected %b", tag, bar, exp_bar);
    end
    checks++;
    assert (fan_on === exp_fan) else begin
      fails++;
      $error("[TB] FAIL %s fan_on: got %b expected %b", tag, fan_on, exp_fan);
    end
    checks++;
    assert (sleep_active === exp_sleep) else begin
      fails++;
      $error("[TB] FAIL %s sleep_active: got %b expected %b", tag, sleep_active, exp_sleep);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("reset", 3'd0, 7'b0000000, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("idle_off", 3'd0, 7'b0000000, 1'b0, 1'b0);

    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("power_on", 3'd1, 7'b0000001, 1'b1, 1'b0);

    pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("up_once", 3'd2, 7'b0000011, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("up_saturate", 3'd7, 7'b1111111, 1'b1, 1'b0);

    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("power_off", 3'd0, 7'b0000000, 1'b0, 1'b0);
    pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    pressBtn(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("off_ignores_up_down", 3'd0, 7'b0000000, 1'b0, 1'b0);
    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restore_level", 3'd7, 7'b1111111, 1'b1, 1'b0);

    pressBtn(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("down_once", 3'd6, 7'b0111111, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) pressBtn(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("down_saturate", 3'd1, 7'b0000001, 1'b1, 1'b0);

    // Hold up for 22 edges: steps at edges 0, 10, 14 and 18
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("hold_first_step", 3'd2, 7'b0000011, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9);
    checkOutput("hold_before_delay", 3'd2, 7'b0000011, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("hold_first_repeat", 3'd3, 7'b0000111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("hold_22_cycles", 3'd5, 7'b0011111, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("up_down_together", 3'd5, 7'b0011111, 1'b1, 1'b0);

    pressBtn(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("power_beats_up", 3'd0, 7'b0000000, 1'b0, 1'b0);
    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("level_kept", 3'd5, 7'b0011111, 1'b1, 1'b0);

`ifdef FAN_LEVEL_CTRL_SLEEP_EN
    pressBtn(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("enter_sleep", 3'd5, 7'b0011111, 1'b1, 1'b1);
    pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("sleep_up", 3'd6, 7'b0111111, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 96);
    checkOutput("sleep_edge_99", 3'd6, 7'b0111111, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("sleep_expired", 3'd0, 7'b0000000, 1'b0, 1'b0);
    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wake_prior_level", 3'd6, 7'b0111111, 1'b1, 1'b0);
    pressBtn(1'b0, 1'b0, 1'b0, 1'b1);
    pressBtn(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sleep_cancel", 3'd6, 7'b0111111, 1'b1, 1'b0);
`else
    pressBtn(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sleep_ignored", 3'd5, 7'b0011111, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 7; i++) pressBtn(1'b0, 1'b0, 1'b1, 1'b0);
    pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    pressBtn(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("level_three", 3'd3, 7'b0000111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5);
    checkOutput("mid_repeat", 3'd4, 7'b0001111, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 3'd0, 7'b0000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("off_after_reset", 3'd0, 7'b0000000, 1'b0, 1'b0);
    pressBtn(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("init_level_after_reset", 3'd1, 7'b0000001, 1'b1, 1'b0);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("held_at_release", 3'd1, 7'b0000001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("held_no_retoggle", 3'd1, 7'b0000001, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
